clarvi_slice_sequencer: RTL and testbench

Issue-side companion to the 16-bit sliced ALU. It accepts one 64-bit operation (instruction, two 64-bit operands, 64-bit immediate) over a valid/ready handshake. It drives the ALU with four 16-bit slices in the part order that operation requires, with `stall` gating the ALU's inter-part state. It then collects the four 16-bit slice results into a 64-bit result, presented on a second valid/ready handshake. It sits between decode/operand-read and writeback.

---
 rtl/clarvi_slice_sequencer_pkg.sv | 54 +++++
 rtl/clarvi_slice_mux.sv | 30 +++
 rtl/clarvi_slice_sequencer.sv | 103 ++++++++++
 tb/tb_clarvi_slice_sequencer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/clarvi_slice_sequencer_pkg.sv
// Shared types and helpers for the 16-bit sliced ALU issue path.
// Defines the instruction word, the slice part orders and the per-op order selection.
package clarvi_slice_sequencer_pkg;

  localparam int unsigned XLEN      = 64;
  localparam int unsigned SLICE_W   = 16;
  localparam int unsigned NUM_PARTS = 4;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_SL, OP_SRL, OP_SRA, OP_SLT, OP_SLTU, OP_XOR, OP_OR, OP_AND
  } op_t;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    op_t                op;
    logic [SLICE_W-1:0] immediate;
    logic               immediate_used;
    logic               is32_bit_op;
    logic [1:0]         instr_part;
  } instr_t;

  typedef enum logic [1:0] {ORDER_FWD, ORDER_REV, ORDER_W_RSHIFT} slice_order_t;

  function automatic logic [1:0] part_for_step(slice_order_t order, logic [1:0] step);
    logic [1:0] p;
    case (order)
      ORDER_REV:      p = ~step;
      ORDER_W_RSHIFT: p = {step[1], ~step[0]};
      default:        p = step;
    endcase
    return p;
  endfunction

  function automatic logic is_shift(op_t op);
    return (op == OP_SL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

  // Ops whose result flows downward start at the top part; 32-bit right shifts
  // work the low word top-down first, then fill the sign-extended upper word.
  function automatic slice_order_t order_for(instr_t instr);
    slice_order_t o;
    o = ORDER_FWD;
    case (instr.op)
      OP_SLT, OP_SLTU: o = ORDER_REV;
      OP_SRL, OP_SRA: begin
        if (instr.is32_bit_op) o = ORDER_W_RSHIFT;
        else                   o = ORDER_REV;
      end
      default: o = ORDER_FWD;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/clarvi_slice_mux.sv
// Selects the operand and immediate slices presented to the ALU for one part.
module clarvi_slice_mux
  import clarvi_slice_sequencer_pkg::*;
(
  input  logic [XLEN-1:0]    rs1,
  input  logic [XLEN-1:0]    rs2,
  input  logic [XLEN-1:0]    imm,
  input  logic [1:0]         part,
  input  op_t                op,
  output logic [SLICE_W-1:0] rs1_slice,
  output logic [SLICE_W-1:0] rs2_slice,
  output logic [SLICE_W-1:0] imm_slice
);

  logic [5:0] lsb;

  assign lsb = {part, 4'b0000};

  // Shifts need the full shift amount on every part, not a slice of it.
  always_comb begin
    rs1_slice = rs1[lsb +: SLICE_W];
    rs2_slice = rs2[lsb +: SLICE_W];
    imm_slice = imm[lsb +: SLICE_W];
    if (is_shift(op)) begin
      rs2_slice = rs2[SLICE_W-1:0];
      imm_slice = imm[SLICE_W-1:0];
    end
  end

endmodule

// File: rtl/clarvi_slice_sequencer.sv
// Issues one 64-bit operation to the 16-bit sliced ALU as four ordered parts
// and reassembles the slice results behind a valid/ready handshake.
module clarvi_slice_sequencer
  import clarvi_slice_sequencer_pkg::*;
(
  input  logic               clock,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  instr_t             in_instr,
  input  logic [XLEN-1:0]    in_rs1,
  input  logic [XLEN-1:0]    in_rs2,
  input  logic [XLEN-1:0]    in_imm,
  output instr_t             alu_instr,
  output logic [SLICE_W-1:0] alu_rs1,
  output logic [SLICE_W-1:0] alu_rs2,
  output logic               alu_stall,
  input  logic [SLICE_W-1:0] alu_result,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_result
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state, state_next;
  logic [1:0]         step;
  slice_order_t       order;
  instr_t             lat_instr;
  logic [XLEN-1:0]    lat_rs1, lat_rs2, lat_imm;
  logic [1:0]         part;
  logic [5:0]         result_lsb;
  logic [SLICE_W-1:0] imm_slice;
  logic               accept;
  logic               last_step;

  assign in_ready   = (state == S_IDLE) || ((state == S_DONE) && out_ready);
  assign accept     = in_valid && in_ready;
  assign last_step  = (step == 2'(NUM_PARTS - 1));
  assign part       = part_for_step(order, step);
  assign result_lsb = {part, 4'b0000};
  assign out_valid  = (state == S_DONE);
  assign alu_stall  = (state != S_RUN);

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (accept) state_next = S_RUN;
      S_RUN:  if (last_step) state_next = S_DONE;
      S_DONE: begin
        if (out_ready) begin
          if (accept) state_next = S_RUN;
          else        state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    alu_instr            = lat_instr;
    alu_instr.instr_part = part;
    alu_instr.immediate  = imm_slice;
  end

  clarvi_slice_mux u_mux (
    .rs1       (lat_rs1),
    .rs2       (lat_rs2),
    .imm       (lat_imm),
    .part      (part),
    .op        (lat_instr.op),
    .rs1_slice (alu_rs1),
    .rs2_slice (alu_rs2),
    .imm_slice (imm_slice)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      step       <= '0;
      order      <= ORDER_FWD;
      lat_instr  <= '0;
      lat_rs1    <= '0;
      lat_rs2    <= '0;
      lat_imm    <= '0;
      out_result <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        step      <= '0;
        order     <= order_for(in_instr);
        lat_instr <= in_instr;
        lat_rs1   <= in_rs1;
        lat_rs2   <= in_rs2;
        lat_imm   <= in_imm;
      end else if (state == S_RUN) begin
        step <= step + 2'd1;
      end
      if (state == S_RUN) out_result[result_lsb +: SLICE_W] <= alu_result;
    end
  end

endmodule

// File: tb/tb_clarvi_slice_sequencer.sv
// Directed bench: a behavioural sliced ALU feeds the sequencer; part order,
// operand slices, latency, backpressure and reset abandonment are checked.
module tb_clarvi_slice_sequencer;
  import clarvi_slice_sequencer_pkg::*;

  logic         clock;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  instr_t       in_instr;
  logic [63:0]  in_rs1, in_rs2, in_imm;
  instr_t       alu_instr;
  logic [15:0]  alu_rs1, alu_rs2;
  logic         alu_stall;
  logic [15:0]  alu_result;
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  out_result;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;

  clarvi_slice_sequencer dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_imm     (in_imm),
    .alu_instr  (alu_instr),
    .alu_rs1    (alu_rs1),
    .alu_rs2    (alu_rs2),
    .alu_stall  (alu_stall),
    .alu_result (alu_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural sliced ALU: inter-part state is the operand slices already seen,
  // advanced only on unstalled edges; each part sees only parts fed so far.
  logic [63:0] acc_a = '0;
  logic [63:0] acc_b = '0;
  logic [5:0]  mlsb, amt;
  logic [63:0] ma, mb, f;
  logic [15:0] bsl;
  logic [31:0] w;

  always_comb begin
    mlsb = {alu_instr.instr_part, 4'b0000};
    bsl  = alu_instr.immediate_used ? alu_instr.immediate : alu_rs2;
    amt  = bsl[5:0];
    ma   = acc_a;
    mb   = acc_b;
    ma[mlsb +: 16] = alu_rs1;
    mb[mlsb +: 16] = bsl;
    case (alu_instr.op)
      OP_ADD:  f = ma + mb;
      OP_SUB:  f = ma - mb;
      OP_SL:   f = ma << amt;
      OP_SRL:  f = ma >> amt;
      OP_SRA:  f = 64'($signed(ma) >>> amt);
      OP_SLT:  f = {63'b0, ($signed(ma) < $signed(mb))};
      OP_SLTU: f = {63'b0, (ma < mb)};
      OP_XOR:  f = ma ^ mb;
      OP_OR:   f = ma | mb;
      OP_AND:  f = ma & mb;
      default: f = '0;
    endcase
    w = f[31:0];
    if (alu_instr.is32_bit_op) begin
      case (alu_instr.op)
        OP_SL:   w = ma[31:0] << amt[4:0];
        OP_SRL:  w = ma[31:0] >> amt[4:0];
        OP_SRA:  w = 32'($signed(ma[31:0]) >>> amt[4:0]);
        default: w = f[31:0];
      endcase
      f = {{32{w[31]}}, w};
    end
    alu_result = f[mlsb +: 16];
  end

  always_ff @(posedge clock) begin
    if (!alu_stall) begin
      acc_a[mlsb +: 16] <= alu_rs1;
      acc_b[mlsb +: 16] <= bsl;
    end
  end

  task automatic check_vec(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic instr_t mk_instr(op_t op, logic iu, logic w32);
    instr_t i;
    i.pc             = 64'h0000_0000_8000_1000;
    i.op             = op;
    i.immediate      = 16'hDEAD;
    i.immediate_used = iu;
    i.is32_bit_op    = w32;
    i.instr_part     = 2'b10;
    return i;
  endfunction

  task automatic scramble();
    in_instr = mk_instr(OP_OR, 1'b1, 1'b1);
    in_rs1   = {$urandom, $urandom};
    in_rs2   = {$urandom, $urandom};
    in_imm   = {$urandom, $urandom};
  endtask

  task automatic issue(input string tag, input instr_t ins, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] im);
    @(negedge clock);
    in_valid = 1'b1;
    in_instr = ins;
    in_rs1   = a;
    in_rs2   = b;
    in_imm   = im;
    #1;
    check_vec({tag, " in_ready"}, 96'(in_ready), 96'(1'b1));
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    scramble();
  endtask

  // ordv packs the expected part for steps 0..3, two bits each, step 0 in the MSBs.
  task automatic watch_parts(input string tag, input logic [7:0] ordv, input logic [63:0] a,
                             input logic [63:0] b, input logic [63:0] im, input bit shift);
    logic [7:0]  t;
    logic [1:0]  ep;
    logic [63:0] sa, sb, si;
    for (int s = 0; s < 4; s++) begin
      @(negedge clock);
      t  = ordv << (2 * s);
      ep = t[7:6];
      sa = a >> {ep, 4'b0000};
      sb = shift ? b : (b >> {ep, 4'b0000});
      si = shift ? im : (im >> {ep, 4'b0000});
      check_vec($sformatf("%s s%0d part", tag, s), 96'(alu_instr.instr_part), 96'(ep));
      check_vec($sformatf("%s s%0d stall", tag, s), 96'(alu_stall), 96'(1'b0));
      check_vec($sformatf("%s s%0d out_valid", tag, s), 96'(out_valid), 96'(1'b0));
      check_vec($sformatf("%s s%0d rs1", tag, s), 96'(alu_rs1), 96'(sa[15:0]));
      check_vec($sformatf("%s s%0d rs2", tag, s), 96'(alu_rs2), 96'(sb[15:0]));
      check_vec($sformatf("%s s%0d imm", tag, s), 96'(alu_instr.immediate), 96'(si[15:0]));
      check_vec($sformatf("%s s%0d pc", tag, s), 96'(alu_instr.pc), 96'(64'h0000_0000_8000_1000));
      @(posedge clock);
    end
  endtask

  task automatic collect(input string tag, input logic [63:0] exp);
    @(negedge clock);
    check_vec({tag, " out_valid"}, 96'(out_valid), 96'(1'b1));
    check_vec({tag, " result"}, 96'(out_result), 96'(exp));
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic run_op(input string tag, input instr_t ins, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] im, input logic [7:0] ordv,
                        input bit shift, input logic [63:0] exp);
    issue(tag, ins, a, b, im);
    watch_parts(tag, ordv, a, b, im, shift);
    collect(tag, exp);
  endtask

  localparam logic [7:0] ORD_FWD = 8'b00_01_10_11;
  localparam logic [7:0] ORD_REV = 8'b11_10_01_00;
  localparam logic [7:0] ORD_WRS = 8'b01_00_11_10;

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_instr  = '0;
    in_rs1    = '0;
    in_rs2    = '0;
    in_imm    = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_vec("rst in_ready", 96'(in_ready), 96'(1'b1));
    check_vec("rst out_valid", 96'(out_valid), 96'(1'b0));
    check_vec("rst out_result", 96'(out_result), 96'(64'h0));
    check_vec("rst stall", 96'(alu_stall), 96'(1'b1));
    check_vec("rst alu_rs1", 96'(alu_rs1), 96'(16'h0));
    check_vec("rst alu_rs2", 96'(alu_rs2), 96'(16'h0));
    check_vec("rst alu_instr", 96'(alu_instr), 96'(0));
    reset_n = 1'b1;

    run_op("add", mk_instr(OP_ADD, 1'b0, 1'b0), 64'h0000_0000_FFFF_FFFF, 64'h1, 64'h0,
           ORD_FWD, 1'b0, 64'h0000_0001_0000_0000);
    run_op("sltu", mk_instr(OP_SLTU, 1'b0, 1'b0), 64'h0001_0000_0000_0000,
           64'h0000_FFFF_FFFF_FFFF, 64'h0, ORD_REV, 1'b0, 64'h0);
    run_op("slt", mk_instr(OP_SLT, 1'b0, 1'b0), 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0,
           ORD_REV, 1'b0, 64'h1);
    run_op("sraw", mk_instr(OP_SRA, 1'b0, 1'b1), 64'h0000_0000_8000_0000, 64'h4, 64'h0,
           ORD_WRS, 1'b1, 64'hFFFF_FFFF_F800_0000);
    run_op("sli", mk_instr(OP_SL, 1'b1, 1'b0), 64'h1, 64'h3, 64'd40,
           ORD_FWD, 1'b1, 64'h0000_0100_0000_0000);
    run_op("andi", mk_instr(OP_AND, 1'b1, 1'b0), 64'h1234_5678_9ABC_DEF0, 64'h0,
           64'hFF00_FF00_FF00_FF00, ORD_FWD, 1'b0, 64'h1200_5600_9A00_DE00);

    issue("xor", mk_instr(OP_XOR, 1'b0, 1'b0), 64'hAAAA_5555_0F0F_F0F0,
          64'hFFFF_0000_FFFF_0000, 64'h0);
    watch_parts("xor", ORD_FWD, 64'hAAAA_5555_0F0F_F0F0, 64'hFFFF_0000_FFFF_0000, 64'h0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      in_valid = 1'b1;
      in_instr = mk_instr(OP_ADD, 1'b0, 1'b0);
      #1;
      check_vec($sformatf("bp%0d out_valid", c), 96'(out_valid), 96'(1'b1));
      check_vec($sformatf("bp%0d result", c), 96'(out_result), 96'(64'h5555_5555_F0F0_F0F0));
      check_vec($sformatf("bp%0d in_ready", c), 96'(in_ready), 96'(1'b0));
      check_vec($sformatf("bp%0d stall", c), 96'(alu_stall), 96'(1'b1));
      check_vec($sformatf("bp%0d op", c), 96'(alu_instr.op), 96'(OP_XOR));
    end
    @(negedge clock);
    in_valid  = 1'b1;
    in_instr  = mk_instr(OP_SUB, 1'b0, 1'b0);
    in_rs1    = 64'h0001_0000_0000_0000;
    in_rs2    = 64'h1;
    in_imm    = 64'h0;
    out_ready = 1'b1;
    #1;
    check_vec("b2b in_ready", 96'(in_ready), 96'(1'b1));
    check_vec("b2b old result", 96'(out_result), 96'(64'h5555_5555_F0F0_F0F0));
    @(posedge clock);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    scramble();
    watch_parts("sub", ORD_FWD, 64'h0001_0000_0000_0000, 64'h1, 64'h0, 1'b0);
    collect("sub", 64'h0000_FFFF_FFFF_FFFF);

    issue("abort", mk_instr(OP_ADD, 1'b0, 1'b0), 64'h1111, 64'h2222, 64'h0);
    repeat (3) @(negedge clock);
    check_vec("abort part", 96'(alu_instr.instr_part), 96'(2'd2));
    reset_n = 1'b0;
    #1;
    check_vec("abort out_valid", 96'(out_valid), 96'(1'b0));
    check_vec("abort in_ready", 96'(in_ready), 96'(1'b1));
    check_vec("abort stall", 96'(alu_stall), 96'(1'b1));
    check_vec("abort result", 96'(out_result), 96'(64'h0));
    @(negedge clock);
    reset_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      check_vec($sformatf("post%0d out_valid", c), 96'(out_valid), 96'(1'b0));
      check_vec($sformatf("post%0d in_ready", c), 96'(in_ready), 96'(1'b1));
    end
    run_op("add57", mk_instr(OP_ADD, 1'b0, 1'b0), 64'd5, 64'd7, 64'h0, ORD_FWD, 1'b0, 64'd12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
